// File: rtl/dual_issue_scoreboard.sv
// Dual-issue controller: picks 0, 1 or 2 instructions from the buffer head each
// cycle using a per-register busy scoreboard, pair dependencies and unit limits.
module dual_issue_scoreboard #(
  parameter int XLEN    = 32,
  parameter int NUM_REG = 32
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        flush,
  input  logic        stall,
  input  logic        queueEmpty,
  input  logic        queueOne,
  input  logic [31:0] insA,
  input  logic [31:0] insB,
  output logic        pop,
  output logic        popTwo,
  input  logic        wbEnA,
  input  logic        wbEnB,
  input  logic [4:0]  wbRegA,
  input  logic [4:0]  wbRegB,
  output logic        issueValidA,
  output logic        issueValidB,
  output logic [31:0] issueInsA,
  output logic [31:0] issueInsB
);
  localparam int          RW  = $clog2(NUM_REG);
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd;
    logic          rs1_used;
    logic          rs2_used;
    logic          rd_used;
    logic          mem;
    logic          ctrl;
  } dec_t;

  // SYSTEM, MISC-MEM and unknown opcodes fall into the default: control, no registers.
  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d          = '0;
    d.rs1      = ins[15 +: RW];
    d.rs2      = ins[20 +: RW];
    d.rd       = ins[7 +: RW];
    case (ins[6:0])
      OPC_LUI, OPC_AUIPC: d.rd_used = 1'b1;
      OPC_JAL:    begin d.rd_used = 1'b1; d.ctrl = 1'b1; end
      OPC_JALR:   begin d.rs1_used = 1'b1; d.rd_used = 1'b1; d.ctrl = 1'b1; end
      OPC_BRANCH: begin d.rs1_used = 1'b1; d.rs2_used = 1'b1; d.ctrl = 1'b1; end
      OPC_LOAD:   begin d.rs1_used = 1'b1; d.rd_used = 1'b1; d.mem = 1'b1; end
      OPC_STORE:  begin d.rs1_used = 1'b1; d.rs2_used = 1'b1; d.mem = 1'b1; end
      OPC_OPIMM:  begin d.rs1_used = 1'b1; d.rd_used = 1'b1; end
      OPC_OP:     begin d.rs1_used = 1'b1; d.rs2_used = 1'b1; d.rd_used = 1'b1; end
      default:    d.ctrl = 1'b1;
    endcase
    d.rd_used = d.rd_used && (d.rd != '0);
    return d;
  endfunction

  function automatic logic busy_hazard(input dec_t d, input logic [NUM_REG-1:0] busy);
    return (d.rs1_used && busy[d.rs1]) || (d.rs2_used && busy[d.rs2]) ||
           (d.rd_used && busy[d.rd]);
  endfunction

  logic [NUM_REG-1:0] busy_q, busy_d;
  logic               valid_a_q, valid_b_q;
  logic [31:0]        ins_a_q, ins_b_q;
  dec_t               dec_a, dec_b;
  logic               issue_a, issue_b;
  logic               pair_raw, pair_waw;

  logic [XLEN-1:0] unused_xlen;
  logic            unused_ok;
  assign unused_xlen = '0;
  assign unused_ok   = ^{insA, insB, wbRegA, wbRegB, unused_xlen};

  assign dec_a = decode(insA);
  assign dec_b = decode(insB);

  always_comb begin
    pair_raw = dec_a.rd_used &&
               ((dec_b.rs1_used && dec_b.rs1 == dec_a.rd) ||
                (dec_b.rs2_used && dec_b.rs2 == dec_a.rd));
    pair_waw = dec_a.rd_used && dec_b.rd_used && (dec_b.rd == dec_a.rd);
    issue_a  = resetn && !queueEmpty && !stall && !flush && !busy_hazard(dec_a, busy_q);
    issue_b  = issue_a && !queueOne && !busy_hazard(dec_b, busy_q) &&
               !dec_a.ctrl && !dec_b.ctrl && !(dec_a.mem && dec_b.mem) &&
               !pair_raw && !pair_waw;
  end

  assign pop    = issue_a;
  assign popTwo = issue_b;

  // Issued writers are applied after writeback clears so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (wbEnA) busy_d[wbRegA[RW-1:0]] = 1'b0;
    if (wbEnB) busy_d[wbRegB[RW-1:0]] = 1'b0;
    if (issue_a && dec_a.rd_used) busy_d[dec_a.rd] = 1'b1;
    if (issue_b && dec_b.rd_used) busy_d[dec_b.rd] = 1'b1;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy_q    <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      ins_a_q   <= NOP;
      ins_b_q   <= NOP;
    end else begin
      busy_q <= busy_d;
      if (flush) begin
        valid_a_q <= 1'b0;
        valid_b_q <= 1'b0;
      end else if (!stall) begin
        valid_a_q <= issue_a;
        valid_b_q <= issue_b;
      end
      if (issue_a) ins_a_q <= insA;
      if (issue_b) ins_b_q <= insB;
    end
  end

  assign issueValidA = valid_a_q;
  assign issueValidB = valid_b_q;
  assign issueInsA   = ins_a_q;
  assign issueInsB   = ins_b_q;

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Self-checking bench for dual_issue_scoreboard: issued instructions are queued
// when a pop is expected and compared when they appear on the issue registers.
module tb_dual_issue_scoreboard;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        resetn, flush, stall, queueEmpty, queueOne;
  logic [31:0] insA, insB;
  logic        pop, popTwo;
  logic        wbEnA, wbEnB;
  logic [4:0]  wbRegA, wbRegB;
  logic        issueValidA, issueValidB;
  logic [31:0] issueInsA, issueInsB;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_busy = '0;
  logic [31:0] e, la, lb;

  always #5 clock = ~clock;

  dual_issue_scoreboard #(.XLEN(32), .NUM_REG(32)) dut (
    .clock(clock), .resetn(resetn), .flush(flush), .stall(stall),
    .queueEmpty(queueEmpty), .queueOne(queueOne), .insA(insA), .insB(insB),
    .pop(pop), .popTwo(popTwo), .wbEnA(wbEnA), .wbEnB(wbEnB),
    .wbRegA(wbRegA), .wbRegB(wbRegB), .issueValidA(issueValidA),
    .issueValidB(issueValidB), .issueInsA(issueInsA), .issueInsB(issueInsB)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- encoders ----------------
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
  endfunction
  function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
    return {7'b0, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], 3'b010, rd[4:0], 7'b0000011};
  endfunction
  function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] beq(input int rs1, input int rs2);
    return {7'b0, rs2[4:0], rs1[4:0], 3'b000, 5'b0, 7'b1100011};
  endfunction
  function automatic logic [31:0] jal(input int rd);
    return {20'b0, rd[4:0], 7'b1101111};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_ins(input logic qe, input logic qo, input logic [31:0] a, input logic [31:0] b);
    queueEmpty = qe;
    queueOne   = qo;
    insA       = a;
    insB       = b;
  endtask

  task automatic drive_wb(input logic ea, input int ra, input logic eb, input int rb);
    wbEnA  = ea;
    wbRegA = ra[4:0];
    wbEnB  = eb;
    wbRegB = rb[4:0];
  endtask

  task automatic idle();
    drive_ins(1'b1, 1'b0, $urandom, $urandom);
    stall = 1'b0;
    flush = 1'b0;
    drive_wb(1'b0, 0, 1'b0, 0);
  endtask

  task automatic sb_pop(output logic [31:0] v);
    if (exp_q.size() != 0) v = exp_q.pop_front();
    else v = 'x;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    idle();
    drive_ins(1'b0, 1'b0, addi(1, 0, 5), addi(2, 0, 7));
    repeat (2) tick();
    checks++; if (pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b expected 0", pop); end
    checks++; if (issueValidA !== 1'b0 || issueValidB !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b%b expected 00", issueValidA, issueValidB); end
    checks++; if (issueInsA !== NOP || issueInsB !== NOP) begin
      errors++; $display("FAIL reset_ins: got %h/%h expected %h", issueInsA, issueInsB, NOP); end
    checks++; if (dut.busy_q !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h expected 0", dut.busy_q); end
    idle();
    @(negedge clock);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_dual_issue();
    logic [31:0] a, b;
    a = addi(1, 0, 5);
    b = addi(2, 0, 7);
    drive_ins(1'b0, 1'b0, a, b);
    @(negedge clock);
    checks++; if (pop !== 1'b1 || popTwo !== 1'b1) begin
      errors++; $display("FAIL dual_pop: got %b%b expected 11", pop, popTwo); end
    exp_q.push_back(a); exp_q.push_back(b);
    tick();
    idle();
    checks++; if (issueValidA !== 1'b1 || issueValidB !== 1'b1) begin
      errors++; $display("FAIL dual_valid: got %b%b expected 11", issueValidA, issueValidB); end
    sb_pop(e);
    checks++; if (issueInsA !== e) begin errors++; $display("FAIL dual_insA: got %h expected %h", issueInsA, e); end
    sb_pop(e);
    checks++; if (issueInsB !== e) begin errors++; $display("FAIL dual_insB: got %h expected %h", issueInsB, e); end
    exp_busy[1] = 1'b1; exp_busy[2] = 1'b1;
    checks++; if (dut.busy_q !== exp_busy) begin errors++; $display("FAIL dual_busy: got %h expected %h", dut.busy_q, exp_busy); end
    drive_wb(1'b1, 1, 1'b1, 2);
    tick();
    drive_wb(1'b0, 0, 1'b0, 0);
    exp_busy = '0;
    checks++; if (dut.busy_q !== exp_busy) begin errors++; $display("FAIL dual_wbclr: got %h expected %h", dut.busy_q, exp_busy); end
  endtask

  task automatic test_raw_hazard();
    logic [31:0] a;
    a = addi(3, 0, $urandom_range(1, 100));
    drive_ins(1'b0, 1'b1, a, $urandom);
    @(negedge clock);
    checks++; if (pop !== 1'b1 || popTwo !== 1'b0) begin
      errors++; $display("FAIL raw_setup_pop: got %b%b expected 10", pop, popTwo); end
    exp_q.push_back(a);
    tick();
    idle();
    sb_pop(e);
    checks++; if (issueValidA !== 1'b1 || issueInsA !== e) begin
      errors++; $display("FAIL raw_setup_ins: got %b/%h expected 1/%h", issueValidA, issueInsA, e); end
    exp_busy[3] = 1'b1;
    a = add(4, 3, 1);
    drive_ins(1'b0, 1'b1, a, $urandom);
    @(negedge clock);
    checks++; if (pop !== 1'b0) begin errors++; $display("FAIL raw_block_pop: got %b expected 0", pop); end
    tick();
    checks++; if (issueValidA !== 1'b0) begin errors++; $display("FAIL raw_block_valid: got %b expected 0", issueValidA); end
    drive_wb(1'b1, 3, 1'b0, 0);
    @(negedge clock);
    checks++; if (pop !== 1'b0) begin errors++; $display("FAIL raw_nobypass: got %b expected 0", pop); end
    tick();
    drive_wb(1'b0, 0, 1'b0, 0);
    exp_busy[3] = 1'b0;
    @(negedge clock);
    checks++; if (pop !== 1'b1) begin errors++; $display("FAIL raw_release_pop: got %b expected 1", pop); end
    exp_q.push_back(a);
    tick();
    idle();
    sb_pop(e);
    checks++; if (issueValidA !== 1'b1 || issueInsA !== e) begin
      errors++; $display("FAIL raw_release_ins: got %b/%h expected 1/%h", issueValidA, issueInsA, e); end
    exp_busy[4] = 1'b1;
    checks++; if (dut.busy_q !== exp_busy) begin errors++; $display("FAIL raw_busy: got %h expected %h", dut.busy_q, exp_busy); end
  endtask

  task automatic test_pair_raw();
    logic [31:0] a, b;
    a = addi(5, 0, 1);
    b = add(6, 5, 5);
    drive_ins(1'b0, 1'b0, a, b);
    @(negedge clock);
    checks++; if (pop !== 1'b1 || popTwo !== 1'b0) begin
      errors++; $display("FAIL pair_raw_pop: got %b%b expected 10", pop, popTwo); end
    exp_q.push_back(a);
    tick();
    sb_pop(e);
    checks++; if (issueValidA !== 1'b1 || issueValidB !== 1'b0 || issueInsA !== e) begin
      errors++; $display("FAIL pair_raw_issue: got %b%b/%h expected 10/%h", issueValidA, issueValidB, issueInsA, e); end
    exp_busy[5] = 1'b1;
    drive_ins(1'b0, 1'b1, b, $urandom);
    @(negedge clock);
    checks++; if (pop !== 1'b0) begin errors++; $display("FAIL pair_raw_wait: got %b expected 0", pop); end
    drive_wb(1'b1, 5, 1'b0, 0);
    tick();
    drive_wb(1'b0, 0, 1'b0, 0);
    exp_busy[5] = 1'b0;
    @(negedge clock);
    checks++; if (pop !== 1'b1) begin errors++; $display("FAIL pair_raw_release: got %b expected 1", pop); end
    exp_q.push_back(b);
    tick();
    idle();
    sb_pop(e);
    checks++; if (issueValidA !== 1'b1 || issueInsA !== e) begin
      errors++; $display("FAIL pair_raw_B: got %b/%h expected 1/%h", issueValidA, issueInsA, e); end
    exp_busy[6] = 1'b1;
    checks++; if (dut.busy_q !== exp_busy) begin errors++; $display("FAIL pair_raw_busy: got %h expected %h", dut.busy_q, exp_busy); end
    drive_wb(1'b1, 4, 1'b1, 6);
    tick();
    drive_wb(1'b0, 0, 1'b0, 0);
    exp_busy = '0;
  endtask

  task automatic test_structural();
    logic [31:0] ta[4], tb_ins[4];
    int          wra[4], wrb[4];
    logic        two[4];
    ta[0] = lw(7, 8, 0);     tb_ins[0] = sw(9, 8, 4);    wra[0] = 7;  wrb[0] = 0;  two[0] = 1'b0;
    ta[1] = beq(1, 2);       tb_ins[1] = addi(11, 0, 3); wra[1] = 0;  wrb[1] = 0;  two[1] = 1'b0;
    ta[2] = addi(12, 0, 1);  tb_ins[2] = jal(13);        wra[2] = 12; wrb[2] = 0;  two[2] = 1'b0;
    ta[3] = add(22, 0, 0);   tb_ins[3] = lw(23, 8, 0);   wra[3] = 22; wrb[3] = 23; two[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_ins(1'b0, 1'b0, ta[i], tb_ins[i]);
      @(negedge clock);
      checks++; if (pop !== 1'b1 || popTwo !== two[i]) begin
        errors++; $display("FAIL struct_pop[%0d]: got %b%b expected 1%b", i, pop, popTwo, two[i]); end
      exp_q.push_back(ta[i]);
      if (two[i]) exp_q.push_back(tb_ins[i]);
      tick();
      idle();
      sb_pop(e);
      checks++; if (issueValidA !== 1'b1 || issueValidB !== two[i] || issueInsA !== e) begin
        errors++; $display("FAIL struct_issue[%0d]: got %b%b/%h expected 1%b/%h", i, issueValidA, issueValidB, issueInsA, two[i], e); end
      if (two[i]) begin
        sb_pop(e);
        checks++; if (issueInsB !== e) begin errors++; $display("FAIL struct_insB[%0d]: got %h expected %h", i, issueInsB, e); end
      end
      if (wra[i] != 0) exp_busy[wra[i]] = 1'b1;
      if (wrb[i] != 0) exp_busy[wrb[i]] = 1'b1;
      checks++; if (dut.busy_q !== exp_busy) begin
        errors++; $display("FAIL struct_busy[%0d]: got %h expected %h", i, dut.busy_q, exp_busy); end
      drive_wb(1'b1, wra[i], 1'b1, wrb[i]);
      tick();
      drive_wb(1'b0, 0, 1'b0, 0);
      exp_busy = '0;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    a = addi(10, 0, 1);
    drive_ins(1'b0, 1'b1, a, $urandom);
    @(negedge clock);
    checks++; if (pop !== 1'b1) begin errors++; $display("FAIL b2b_first_pop: got %b expected 1", pop); end
    exp_q.push_back(a);
    tick();
    idle();
    sb_pop(e);
    checks++; if (issueInsA !== e) begin errors++; $display("FAIL b2b_first_ins: got %h expected %h", issueInsA, e); end
    drive_wb(1'b1, 10, 1'b0, 0);
    tick();
    a = addi(10, 0, 2);
    drive_ins(1'b0, 1'b1, a, $urandom);
    drive_wb(1'b0, 0, 1'b1, 10);
    @(negedge clock);
    checks++; if (pop !== 1'b1) begin errors++; $display("FAIL b2b_second_pop: got %b expected 1", pop); end
    exp_q.push_back(a);
    tick();
    idle();
    sb_pop(e);
    la = e;
    checks++; if (issueInsA !== e) begin errors++; $display("FAIL b2b_second_ins: got %h expected %h", issueInsA, e); end
    exp_busy[10] = 1'b1;
    checks++; if (dut.busy_q !== exp_busy) begin errors++; $display("FAIL b2b_setwins: got %h expected %h", dut.busy_q, exp_busy); end
    drive_ins(1'b0, 1'b0, addi(14, 0, 1), addi(15, 0, 1));
    flush = 1'b1;
    @(negedge clock);
    checks++; if (pop !== 1'b0 || popTwo !== 1'b0) begin
      errors++; $display("FAIL flush_pop: got %b%b expected 00", pop, popTwo); end
    tick();
    idle();
    exp_busy = '0;
    checks++; if (issueValidA !== 1'b0 || issueValidB !== 1'b0) begin
      errors++; $display("FAIL flush_valid: got %b%b expected 00", issueValidA, issueValidB); end
    checks++; if (dut.busy_q !== exp_busy) begin errors++; $display("FAIL flush_busy: got %h expected %h", dut.busy_q, exp_busy); end
    checks++; if (issueInsA !== la) begin errors++; $display("FAIL flush_ins_hold: got %h expected %h", issueInsA, la); end
  endtask

  task automatic test_stall();
    logic [31:0] a, b;
    a = addi(16, 0, $urandom_range(0, 2047));
    b = addi(17, 0, $urandom_range(0, 2047));
    drive_ins(1'b0, 1'b0, a, b);
    exp_q.push_back(a); exp_q.push_back(b);
    tick();
    sb_pop(la); sb_pop(lb);
    checks++; if (issueValidA !== 1'b1 || issueValidB !== 1'b1 || issueInsA !== la || issueInsB !== lb) begin
      errors++; $display("FAIL stall_pre: got %b%b/%h/%h expected 11/%h/%h", issueValidA, issueValidB, issueInsA, issueInsB, la, lb); end
    exp_busy[16] = 1'b1; exp_busy[17] = 1'b1;
    a = addi(18, 0, 3);
    b = addi(19, 0, 4);
    drive_ins(1'b0, 1'b0, a, b);
    stall = 1'b1;
    @(negedge clock);
    checks++; if (pop !== 1'b0 || popTwo !== 1'b0) begin
      errors++; $display("FAIL stall_pop: got %b%b expected 00", pop, popTwo); end
    tick();
    checks++; if (issueValidA !== 1'b1 || issueValidB !== 1'b1 || issueInsA !== la || issueInsB !== lb) begin
      errors++; $display("FAIL stall_hold: got %b%b/%h/%h expected 11/%h/%h", issueValidA, issueValidB, issueInsA, issueInsB, la, lb); end
    checks++; if (dut.busy_q !== exp_busy) begin errors++; $display("FAIL stall_busy: got %h expected %h", dut.busy_q, exp_busy); end
    stall = 1'b0;
    @(negedge clock);
    checks++; if (pop !== 1'b1 || popTwo !== 1'b1) begin
      errors++; $display("FAIL stall_release_pop: got %b%b expected 11", pop, popTwo); end
    exp_q.push_back(a); exp_q.push_back(b);
    tick();
    idle();
    sb_pop(e);
    checks++; if (issueInsA !== e) begin errors++; $display("FAIL stall_release_insA: got %h expected %h", issueInsA, e); end
    sb_pop(e);
    checks++; if (issueInsB !== e) begin errors++; $display("FAIL stall_release_insB: got %h expected %h", issueInsB, e); end
    drive_wb(1'b1, 16, 1'b1, 17);
    tick();
    drive_wb(1'b1, 18, 1'b1, 19);
    tick();
    drive_wb(1'b0, 0, 1'b0, 0);
    exp_busy = '0;
    checks++; if (dut.busy_q !== exp_busy) begin errors++; $display("FAIL stall_cleanup: got %h expected %h", dut.busy_q, exp_busy); end
  endtask

  task automatic test_qone_x0();
    logic [31:0] a;
    a = addi(20, 0, 1);
    drive_ins(1'b0, 1'b1, a, addi(21, 0, 1));
    @(negedge clock);
    checks++; if (pop !== 1'b1 || popTwo !== 1'b0) begin
      errors++; $display("FAIL qone_pop: got %b%b expected 10", pop, popTwo); end
    exp_q.push_back(a);
    tick();
    sb_pop(e);
    checks++; if (issueValidB !== 1'b0 || issueInsA !== e) begin
      errors++; $display("FAIL qone_issue: got %b/%h expected 0/%h", issueValidB, issueInsA, e); end
    exp_busy[20] = 1'b1;
    a = addi(0, 0, $urandom_range(0, 2047));
    drive_ins(1'b0, 1'b1, a, $urandom);
    @(negedge clock);
    checks++; if (pop !== 1'b1) begin errors++; $display("FAIL x0_pop: got %b expected 1", pop); end
    exp_q.push_back(a);
    tick();
    idle();
    sb_pop(e);
    checks++; if (issueInsA !== e) begin errors++; $display("FAIL x0_ins: got %h expected %h", issueInsA, e); end
    checks++; if (dut.busy_q !== exp_busy) begin errors++; $display("FAIL x0_busy: got %h expected %h", dut.busy_q, exp_busy); end
  endtask

  task automatic test_reset_mid();
    drive_ins(1'b0, 1'b0, addi(24, 0, 1), addi(25, 0, 1));
    exp_q.push_back(insA); exp_q.push_back(insB);
    tick();
    sb_pop(e);
    checks++; if (issueInsA !== e) begin errors++; $display("FAIL rmid_pre_insA: got %h expected %h", issueInsA, e); end
    sb_pop(e);
    checks++; if (issueInsB !== e) begin errors++; $display("FAIL rmid_pre_insB: got %h expected %h", issueInsB, e); end
    @(negedge clock);
    resetn = 1'b0;
    #1;
    checks++; if (pop !== 1'b0) begin errors++; $display("FAIL rmid_pop: got %b expected 0", pop); end
    checks++; if (issueValidA !== 1'b0 || issueValidB !== 1'b0) begin
      errors++; $display("FAIL rmid_valid: got %b%b expected 00", issueValidA, issueValidB); end
    checks++; if (issueInsA !== NOP || issueInsB !== NOP) begin
      errors++; $display("FAIL rmid_ins: got %h/%h expected %h", issueInsA, issueInsB, NOP); end
    exp_busy = '0;
    checks++; if (dut.busy_q !== exp_busy) begin errors++; $display("FAIL rmid_busy: got %h expected %h", dut.busy_q, exp_busy); end
    idle();
    tick();
    @(negedge clock);
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_dual_issue();
    test_raw_hazard();
    test_pair_raw();
    test_structural();
    test_back_to_back();
    test_stall();
    test_qone_x0();
    test_reset_mid();
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d entries expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
